ex_stage: RTL and testbench

//  Execute stage, directly downstream of decode. Holds the ID/EX pipeline register and evaluates the 12-op ALU.

---
 rtl/ex_stage.sv | 254 +++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage -- ID/EX register, 12-op ALU, data-SRAM request, optional iterative divider.
// Build with DIVIDER_EN defined to include the divider FSM, HI/LO and MFHI/MFLO.
//
// state  | meaning
// S_IDLE | waiting for DIV/DIVU not yet executed; starts a divide (stallreq=1)
// S_BUSY | one restoring-division step per cycle, 32 steps (stallreq=1)
// S_DONE | HI/LO written at end of cycle, stallreq released
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int STALL_WD     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq
);

  logic [ID_TO_EX_WD-1:0] id_ex_q, id_ex_d;
  logic                   load_en;

  assign load_en = ~stall[2];

  // ID stopped while EX runs: insert a bubble so the held instruction is not duplicated
  always_comb begin
    id_ex_d = id_ex_q;
    if (stall[2] && !stall[3]) begin
      id_ex_d = '0;
    end else if (!stall[2]) begin
      id_ex_d = id_to_ex_bus;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  logic [31:0] pc, inst, rs_data, rt_data;
  logic [11:0] alu_op;
  logic [2:0]  src1;
  logic [3:0]  src2;
  logic        ram_en, rf_we, sel_rf_res;
  logic [3:0]  ram_wen;
  logic [4:0]  rf_waddr;

  assign pc         = id_ex_q[158:127];
  assign inst       = id_ex_q[126:95];
  assign alu_op     = id_ex_q[94:83];
  assign src1       = id_ex_q[82:80];
  assign src2       = id_ex_q[79:76];
  assign ram_en     = id_ex_q[75];
  assign ram_wen    = id_ex_q[74:71];
  assign rf_we      = id_ex_q[70];
  assign rf_waddr   = id_ex_q[69:65];
  assign sel_rf_res = id_ex_q[64];
  assign rs_data    = id_ex_q[63:32];
  assign rt_data    = id_ex_q[31:0];

  logic [31:0] src1_v, src2_v, imm_sext, imm_zext;

  assign imm_sext = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext = {16'b0, inst[15:0]};

  assign src1_v = ({32{src1[0]}} & rs_data)
                | ({32{src1[1]}} & pc)
                | ({32{src1[2]}} & {27'b0, inst[10:6]});

  assign src2_v = ({32{src2[0]}} & rt_data)
                | ({32{src2[1]}} & imm_sext)
                | ({32{src2[2]}} & 32'd8)
                | ({32{src2[3]}} & imm_zext);

  logic [31:0] add_res, sub_res, slt_res, sltu_res, sll_res, srl_res, sra_res, lui_res;
  logic [31:0] alu_res;

  assign add_res  = src1_v + src2_v;
  assign sub_res  = src1_v - src2_v;
  assign slt_res  = {31'b0, $signed(src1_v) < $signed(src2_v)};
  assign sltu_res = {31'b0, src1_v < src2_v};
  assign sll_res  = src2_v << src1_v[4:0];
  assign srl_res  = src2_v >> src1_v[4:0];
  assign sra_res  = 32'($signed(src2_v) >>> src1_v[4:0]);
  assign lui_res  = {src2_v[15:0], 16'b0};

  // alu_op bit 11 is add, bit 0 is lui
  assign alu_res = ({32{alu_op[11]}} & add_res)
                 | ({32{alu_op[10]}} & sub_res)
                 | ({32{alu_op[9]}}  & slt_res)
                 | ({32{alu_op[8]}}  & sltu_res)
                 | ({32{alu_op[7]}}  & (src1_v & src2_v))
                 | ({32{alu_op[6]}}  & ~(src1_v | src2_v))
                 | ({32{alu_op[5]}}  & (src1_v | src2_v))
                 | ({32{alu_op[4]}}  & (src1_v ^ src2_v))
                 | ({32{alu_op[3]}}  & sll_res)
                 | ({32{alu_op[2]}}  & srl_res)
                 | ({32{alu_op[1]}}  & sra_res)
                 | ({32{alu_op[0]}}  & lui_res);

  logic rtype, is_div, is_divu, is_mfhi, is_mflo;

  assign rtype   = (inst[31:26] == 6'b000000);
  assign is_div  = rtype && (inst[5:0] == 6'b011010);
  assign is_divu = rtype && (inst[5:0] == 6'b011011);
  assign is_mfhi = rtype && (inst[5:0] == 6'b010000);
  assign is_mflo = rtype && (inst[5:0] == 6'b010010);

  logic [31:0] hi_val, lo_val;

`ifdef DIVIDER_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        negq_q, negq_d, negr_q, negr_d, dz_q, dz_d, done_q, done_d;
  logic        div_stall;
  logic [32:0] trial, diff;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    dvd_d     = dvd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    dz_d      = dz_q;
    done_d    = done_q;
    div_stall = 1'b0;
    trial     = {rem_q, quo_q[31]};
    diff      = trial - {1'b0, dvs_q};
    case (state_q)
      S_IDLE: begin
        if ((is_div || is_divu) && !done_q) begin
          div_stall = 1'b1;
          state_d   = S_BUSY;
          cnt_d     = 5'd0;
          rem_d     = 32'd0;
          quo_d     = is_div ? abs32(rs_data) : rs_data;
          dvs_d     = is_div ? abs32(rt_data) : rt_data;
          dvd_d     = rs_data;
          negq_d    = is_div && (rs_data[31] ^ rt_data[31]);
          negr_d    = is_div && rs_data[31];
          dz_d      = (rt_data == 32'd0);
        end
      end
      S_BUSY: begin
        div_stall = 1'b1;
        if (trial >= {1'b0, dvs_q}) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        hi_d    = dz_q ? dvd_q : (negr_q ? (32'd0 - rem_q) : rem_q);
        lo_d    = dz_q ? 32'hFFFF_FFFF : (negq_q ? (32'd0 - quo_q) : quo_q);
      end
      default: state_d = S_IDLE;
    endcase
    // a new instruction entering EX re-arms the divider
    if (load_en) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign stallreq = div_stall;
  assign hi_val   = hi_q;
  assign lo_val   = lo_q;
`else
  assign stallreq = 1'b0;
  assign hi_val   = 32'd0;
  assign lo_val   = 32'd0;
`endif

  logic [31:0] result;

  always_comb begin
    result = alu_res;
    if (is_mfhi) begin
      result = hi_val;
    end else if (is_mflo) begin
      result = lo_val;
    end else if (is_div || is_divu) begin
      result = 32'd0;
    end
  end

  assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, result};
  assign data_sram_en    = ram_en;
  assign data_sram_wen   = ram_wen;
  assign data_sram_addr  = result;
  assign data_sram_wdata = rt_data;

  logic unused_bits;
  assign unused_bits = ^{inst[25:16], stall[STALL_WD-1:4], stall[1:0]};

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors for ex_stage; expectations go to a scoreboard queue checked by a monitor.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall, stall_drv;
  logic [158:0] id_bus;
  logic [75:0]  mem_bus;
  logic         sram_en;
  logic [3:0]   sram_wen;
  logic [31:0]  sram_addr, sram_wdata;
  logic         stallreq;

  int checks = 0;
  int errors = 0;

`ifdef DIVIDER_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  localparam logic [11:0] OP_ADD  = 12'b1000_0000_0000;
  localparam logic [11:0] OP_SUB  = 12'b0100_0000_0000;
  localparam logic [11:0] OP_SLT  = 12'b0010_0000_0000;
  localparam logic [11:0] OP_SLTU = 12'b0001_0000_0000;
  localparam logic [11:0] OP_AND  = 12'b0000_1000_0000;
  localparam logic [11:0] OP_NOR  = 12'b0000_0100_0000;
  localparam logic [11:0] OP_OR   = 12'b0000_0010_0000;
  localparam logic [11:0] OP_XOR  = 12'b0000_0001_0000;
  localparam logic [11:0] OP_SLL  = 12'b0000_0000_1000;
  localparam logic [11:0] OP_SRL  = 12'b0000_0000_0100;
  localparam logic [11:0] OP_SRA  = 12'b0000_0000_0010;
  localparam logic [11:0] OP_LUI  = 12'b0000_0000_0001;

  always #5 clk = ~clk;

  // pipeline control: EX stall request freezes IF..EX
  assign stall = stall_drv | (stallreq ? 6'b001111 : 6'b000000);

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_bus),
    .ex_to_mem_bus   (mem_bus),
    .data_sram_en    (sram_en),
    .data_sram_wen   (sram_wen),
    .data_sram_addr  (sram_addr),
    .data_sram_wdata (sram_wdata),
    .stallreq        (stallreq)
  );

  typedef struct {
    string       name;
    logic [75:0] bus;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sreq;
  } exp_t;

  exp_t sb[$];

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic [11:0] op, input logic [2:0] s1,
                                      input logic [3:0] s2, input logic ren,
                                      input logic [3:0] wen, input logic we,
                                      input logic [4:0] wa, input logic sel,
                                      input logic [31:0] rs, input logic [31:0] rt);
    return {pc, inst, op, s1, s2, ren, wen, we, wa, sel, rs, rt};
  endfunction

  function automatic exp_t ex(input string n, input logic [31:0] pc, input logic ren,
                              input logic [3:0] wen, input logic sel, input logic we,
                              input logic [4:0] wa, input logic [31:0] res,
                              input logic [31:0] wd, input logic sr);
    exp_t e;
    e.name  = n;
    e.bus   = {pc, ren, wen, sel, we, wa, res};
    e.en    = ren;
    e.wen   = wen;
    e.addr  = res;
    e.wdata = wd;
    e.sreq  = sr;
    return e;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ({mem_bus, sram_en, sram_wen, sram_addr, sram_wdata, stallreq} !==
          {e.bus, e.en, e.wen, e.addr, e.wdata, e.sreq}) begin
        errors++;
        $display("FAIL %s: got bus=%h en=%b wen=%h addr=%h wdata=%h sreq=%b ; want bus=%h en=%b wen=%h addr=%h wdata=%h sreq=%b",
                 e.name, mem_bus, sram_en, sram_wen, sram_addr, sram_wdata, stallreq,
                 e.bus, e.en, e.wen, e.addr, e.wdata, e.sreq);
      end
    end
  end

  task automatic cyc(input logic [158:0] b, input logic [5:0] s, input exp_t e);
    id_bus    = b;
    stall_drv = s;
    @(posedge clk);
    #1;
    sb.push_back(e);
  endtask

  function automatic exp_t zero(input string n);
    return ex(n, 32'd0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
  endfunction

  localparam logic [31:0] MFHI_I = 32'h0000_1010;
  localparam logic [31:0] MFLO_I = 32'h0000_1012;

  task automatic read_hilo(input string n, input logic [31:0] hi, input logic [31:0] lo);
    cyc(mk(32'h204, MFHI_I, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd0, 32'd0), 6'd0,
        ex({n, "_mfhi"}, 32'h204, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, DIV_ON ? hi : 32'd0, 32'd0, 1'b0));
    cyc(mk(32'h208, MFLO_I, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd0, 32'd0), 6'd0,
        ex({n, "_mflo"}, 32'h208, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, DIV_ON ? lo : 32'd0, 32'd0, 1'b0));
  endtask

  task automatic do_div(input string n, input logic [5:0] func, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] hi, input logic [31:0] lo);
    logic [158:0] d;
    d = mk(32'h200, {6'b0, 5'd4, 5'd5, 10'b0, func}, 12'h0, 3'b0, 4'b0,
           1'b0, 4'h0, 1'b0, 5'd0, 1'b0, rs, rt);
    for (int k = 1; k <= 34; k++) begin
      cyc(d, 6'd0, ex($sformatf("%s_c%0d", n, k), 32'h200, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0,
                      32'd0, rt, DIV_ON && (k <= 33)));
    end
    read_hilo(n, hi, lo);
  endtask

  initial begin
    logic [158:0] va, vb, vd;
    rst       = 1'b0;
    stall_drv = 6'd0;
    id_bus    = mk(32'hABCD0000, 32'h0, OP_ADD, 3'b001, 4'b0001, 1'b1, 4'hF, 1'b1, 5'd7,
                   1'b1, 32'd1, 32'd2);
    #1;
    sb.push_back(zero("reset"));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    cyc(mk(32'hBFC00000, 32'h0, OP_ADD, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0,
           32'h7FFF_FFFF, 32'h1), 6'd0,
        ex("add_wrap", 32'hBFC00000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h8000_0000, 32'h1, 1'b0));

    va = mk(32'h100, 32'h0, OP_ADD, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'd1, 32'd2);
    vb = mk(32'h104, 32'h0, OP_SUB, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'd5, 32'd7);
    cyc(va, 6'd0, ex("stall_a", 32'h100, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'd3, 32'd2, 1'b0));
    cyc(vb, 6'b001100, ex("stall_hold", 32'h100, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'd3, 32'd2, 1'b0));
    cyc(vb, 6'b000100, zero("bubble"));
    cyc(vb, 6'd0, ex("sub_neg", 32'h104, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'hFFFF_FFFE, 32'd7, 1'b0));

    cyc(mk(32'h300, 32'hAC22FFFC, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0,
           32'h1000, 32'hDEADBEEF), 6'd0,
        ex("sw", 32'h300, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_0FFC, 32'hDEADBEEF, 1'b0));
    cyc(mk(32'h304, 32'h8C290010, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd9, 1'b1,
           32'h2000, 32'h0), 6'd0,
        ex("lw", 32'h304, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h0000_2010, 32'h0, 1'b0));

    cyc(mk(32'h400, 32'h3C011234, OP_LUI, 3'b000, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd1, 1'b0,
           32'h0, 32'h0), 6'd0,
        ex("lui", 32'h400, 1'b0, 4'h0, 1'b0, 1'b1, 5'd1, 32'h1234_0000, 32'h0, 1'b0));
    cyc(mk(32'h404, 32'h0000_0100, OP_SLL, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
           32'h55, 32'h1), 6'd0,
        ex("sll", 32'h404, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h10, 32'h1, 1'b0));
    cyc(mk(32'h408, 32'h0, OP_SLTU, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
           32'h1, 32'hFFFF_FFFF), 6'd0,
        ex("sltu", 32'h408, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h1, 32'hFFFF_FFFF, 1'b0));
    cyc(mk(32'h40C, 32'h0, OP_SLT, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
           32'h1, 32'hFFFF_FFFF), 6'd0,
        ex("slt_pos_neg", 32'h40C, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h0, 32'hFFFF_FFFF, 1'b0));
    cyc(mk(32'h410, 32'h0, OP_SLT, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
           32'hFFFF_FFFF, 32'h1), 6'd0,
        ex("slt_neg_pos", 32'h410, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h1, 32'h1, 1'b0));
    cyc(mk(32'h414, 32'h0, OP_AND, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
           32'hF0F0_F0F0, 32'hFF00_FF00), 6'd0,
        ex("and", 32'h414, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'hF000_F000, 32'hFF00_FF00, 1'b0));
    cyc(mk(32'h418, 32'h0, OP_OR, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
           32'hF0F0_F0F0, 32'hFF00_FF00), 6'd0,
        ex("or", 32'h418, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'hFFF0_FFF0, 32'hFF00_FF00, 1'b0));
    cyc(mk(32'h41C, 32'h0, OP_XOR, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
           32'hF0F0_F0F0, 32'hFF00_FF00), 6'd0,
        ex("xor", 32'h41C, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0));
    cyc(mk(32'h420, 32'h0, OP_NOR, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
           32'hF0F0_F0F0, 32'hFF00_FF00), 6'd0,
        ex("nor", 32'h420, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h000F_000F, 32'hFF00_FF00, 1'b0));
    cyc(mk(32'h424, 32'h0000_0100, OP_SRL, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
           32'h0, 32'h8000_0000), 6'd0,
        ex("srl", 32'h424, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h0800_0000, 32'h8000_0000, 1'b0));
    cyc(mk(32'h428, 32'h0, OP_SRA, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
           32'h24, 32'h8000_0000), 6'd0,
        ex("srav_low5", 32'h428, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'hF800_0000, 32'h8000_0000, 1'b0));
    cyc(mk(32'h42C, 32'h3401_8000, OP_OR, 3'b001, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd1, 1'b0,
           32'h0, 32'h0), 6'd0,
        ex("zext_imm", 32'h42C, 1'b0, 4'h0, 1'b0, 1'b1, 5'd1, 32'h0000_8000, 32'h0, 1'b0));
    cyc(mk(32'h430, 32'h3401_8000, OP_ADD, 3'b001, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd1, 1'b0,
           32'h0, 32'h0), 6'd0,
        ex("sext_imm", 32'h430, 1'b0, 4'h0, 1'b0, 1'b1, 5'd1, 32'hFFFF_8000, 32'h0, 1'b0));
    cyc(mk(32'hBFC00010, 32'h0C00_0000, OP_ADD, 3'b010, 4'b0100, 1'b0, 4'h0, 1'b1, 5'd31, 1'b0,
           32'h0, 32'h0), 6'd0,
        ex("link_pc8", 32'hBFC00010, 1'b0, 4'h0, 1'b0, 1'b1, 5'd31, 32'hBFC0_0018, 32'h0, 1'b0));
    cyc(mk(32'h434, 32'h0, 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
           32'h5, 32'h6), 6'd0,
        ex("no_op", 32'h434, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h0, 32'h6, 1'b0));
    cyc(mk(32'h438, 32'h0, OP_ADD, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
           32'h5, 32'h6), 6'd0,
        ex("no_src", 32'h438, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h0, 32'h6, 1'b0));

    do_div("div_m7_2", 6'b011010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_div("divu_5_0", 6'b011011, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    do_div("div_min_m1", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    vd = mk(32'h200, {6'b0, 5'd4, 5'd5, 10'b0, 6'b011011}, 12'h0, 3'b0, 4'b0,
            1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd100, 32'd3);
    for (int k = 1; k <= 10; k++) begin
      cyc(vd, 6'd0, ex($sformatf("divu_rst_c%0d", k), 32'h200, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0,
                       32'd0, 32'd3, DIV_ON));
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    sb.push_back(zero("rst_mid_div"));
    @(negedge clk);
    #1;
    id_bus = mk(32'h204, MFHI_I, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    read_hilo("after_rst", 32'd0, 32'd0);

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: time=%0t want completion before 100000", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
